// File: rtl/binsearch_pkg.sv
// Shared definitions for the binary search controller: default table
// address width and the FSM state encoding.
package binsearch_pkg;

    localparam int ADDR_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROBE = 3'd1,
        ST_EVAL  = 3'd2,
        ST_DONE  = 3'd3,
        ST_MISS  = 3'd4
    } state_t;

endpackage

// File: rtl/binary_search_ctrl.sv
// Binary search sequencer over a sorted external table: narrows a low/high
// window one probe (PROBE + EVAL, two cycles) at a time.
module binary_search_ctrl
    import binsearch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              Found,
    input  logic              Less_Or_Greather,
    output logic [ADDR_W-1:0] search_ADDR,
    output logic              busy,
    output logic              done,
    output logic              not_found
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] low_q, low_d;
    logic [ADDR_W-1:0] high_q, high_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              nf_q, nf_d;

    // Midpoint uses one extra bit so low+high never overflows.
    function automatic logic [ADDR_W-1:0] mid_of(input logic [ADDR_W-1:0] lo,
                                                 input logic [ADDR_W-1:0] hi);
        logic [ADDR_W:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[ADDR_W:1];
    endfunction

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        high_d  = high_q;
        addr_d  = addr_q;
        nf_d    = nf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    low_d   = '0;
                    high_d  = TOP_ADDR;
                    addr_d  = mid_of('0, TOP_ADDR);
                    nf_d    = 1'b0;
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: state_d = ST_EVAL;
            ST_EVAL: begin
                // Bound checks precede the update so the window never wraps.
                if (Found) begin
                    state_d = ST_DONE;
                end else if (Less_Or_Greather) begin
                    if (addr_q == high_q) begin
                        nf_d    = 1'b1;
                        state_d = ST_MISS;
                    end else begin
                        low_d   = addr_q + 1'b1;
                        addr_d  = mid_of(low_d, high_q);
                        state_d = ST_PROBE;
                    end
                end else begin
                    if (addr_q == low_q) begin
                        nf_d    = 1'b1;
                        state_d = ST_MISS;
                    end else begin
                        high_d  = addr_q - 1'b1;
                        addr_d  = mid_of(low_q, high_d);
                        state_d = ST_PROBE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_MISS: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            low_q   <= '0;
            high_q  <= TOP_ADDR;
            addr_q  <= '0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            high_q  <= high_d;
            addr_q  <= addr_d;
            nf_q    <= nf_d;
        end
    end

    assign search_ADDR = addr_q;
    assign busy        = (state_q == ST_PROBE) || (state_q == ST_EVAL);
    assign done        = (state_q == ST_DONE) || (state_q == ST_MISS);
    assign not_found   = nf_q;

endmodule

// File: doc/binary_search_ctrl.md
BINARY_SEARCH_CTRL -- requirements
Module: binary_search_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, address width; searched table depth is 2^ADDR_W entries, sorted ascending.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new search of the current key A; sampled only in IDLE.
REQ-005 Found  input  1  registered equality flag from the compare datapath.
REQ-006 Less_Or_Greather  input  1  registered flag from the compare datapath, 1 = key greater than probed entry, 0 = key less.
REQ-007 search_ADDR  output  ADDR_W  probe address to table memory and datapath.
REQ-008 busy  output  1  high from the cycle after accepted start until DONE/MISS.
REQ-009 done  output  1  one-cycle pulse when search terminates (hit or miss).
REQ-010 not_found  output  1  valid with done; 1 = key absent, held until next accepted start.

Function
REQ-011 States SHALL be IDLE, PROBE, EVAL, DONE, MISS.
REQ-012 IDLE: start=1 loads low=0, high=2^ADDR_W-1, clears not_found, goes to PROBE; start=0 stays.
REQ-013 PROBE: search_ADDR SHALL equal mid=(low+high)>>1, computed at ADDR_W+1 bits, no overflow; always goes to EVAL next cycle.
REQ-014 search_ADDR SHALL be held at mid through PROBE and EVAL, so the datapath registers flags for that address at the end of PROBE.
REQ-015 EVAL, Found=1: go to DONE.
REQ-016 EVAL, Found=0, Less_Or_Greather=1: if mid==high go to MISS, else low=mid+1 and go to PROBE.
REQ-017 EVAL, Found=0, Less_Or_Greather=0: if mid==low go to MISS, else high=mid-1 and go to PROBE.
REQ-018 The mid==high/mid==low checks SHALL occur before the update, so low/high never wrap below 0 or above 2^ADDR_W-1.
REQ-019 DONE: done=1, not_found=0 for one cycle, then IDLE; search_ADDR keeps the hit address.
REQ-020 MISS: done=1, not_found=1 for one cycle, then IDLE.
REQ-021 Each probe SHALL cost exactly 2 cycles; worst case ADDR_W+1 probes.
REQ-022 start asserted outside IDLE SHALL be ignored, not queued.
REQ-023 Key A SHALL be held stable by the source from start until done; the controller does not latch it.

Reset
REQ-024 reset=1 SHALL force IDLE, low=0, high=2^ADDR_W-1, search_ADDR=0, busy=0, done=0, not_found=0 on the next edge.
REQ-025 Reset mid-search SHALL abandon the search with no done pulse.

Structure
REQ-026 Shared package binsearch_pkg SHALL hold ADDR_W default and the state encoding constants.
REQ-027 No sub-module; low/high/mid registers and FSM are in one module, with memory and compare datapath instantiated alongside at top level.

Verification (table mem[i]=2*i, i=0..31)
REQ-028 A=20, start -> probes 15,7,11,9,10; done with not_found=0 on cycle 11 after start; search_ADDR=10.
REQ-029 A=0 -> probes 15,7,3,1,0; hit, search_ADDR=0, no underflow of high.
REQ-030 A=62 -> probes 15,23,27,29,30,31; hit at 31, no overflow of low.
REQ-031 A=21 -> probes 15,7,11,9,10; MISS via mid==high at 10; done=1, not_found=1; A=255 -> MISS at mid=31.
REQ-032 start pulsed again in PROBE/EVAL -> ignored, result unchanged; reset asserted in EVAL -> next cycle IDLE, all outputs 0, no done.
